// File: rtl/cv32e41p_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
//   RF_ADDR_WIDTH / RF_DATA_WIDTH : default integer register file geometry
//   RF_ZERO_ADDR                  : nil register; writes to it are dropped
//   wb_entry_t                    : one pending write (destination + data)
package cv32e41p_pkg;

    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ZERO_ADDR  = 0;

    typedef struct packed {
        logic [RF_ADDR_WIDTH-1:0] addr;
        logic [RF_DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/cv32e41p_rf_wb_arbiter_if.sv
// Writeback bundle between the EX/LSU/APU result producers, the ID hazard
// check and the register file write ports.
//   master : the arbiter (drives apu_ready_o, busy_*_o, write ports A/B)
//   slave  : the surrounding pipeline / register file
interface cv32e41p_rf_wb_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  flush_i;
    logic                  ex_valid_i;
    logic [ADDR_WIDTH-1:0] ex_addr_i;
    logic [DATA_WIDTH-1:0] ex_data_i;
    logic                  lsu_valid_i;
    logic [ADDR_WIDTH-1:0] lsu_addr_i;
    logic [DATA_WIDTH-1:0] lsu_data_i;
    logic                  apu_valid_i;
    logic                  apu_ready_o;
    logic [ADDR_WIDTH-1:0] apu_addr_i;
    logic [DATA_WIDTH-1:0] apu_data_i;
    logic                  issue_i;
    logic [ADDR_WIDTH-1:0] issue_addr_i;
    logic [ADDR_WIDTH-1:0] raddr_a_i;
    logic [ADDR_WIDTH-1:0] raddr_b_i;
    logic [ADDR_WIDTH-1:0] raddr_c_i;
    logic                  busy_a_o;
    logic                  busy_b_o;
    logic                  busy_c_o;
    logic [ADDR_WIDTH-1:0] waddr_a_o;
    logic [DATA_WIDTH-1:0] wdata_a_o;
    logic                  we_a_o;
    logic [ADDR_WIDTH-1:0] waddr_b_o;
    logic [DATA_WIDTH-1:0] wdata_b_o;
    logic                  we_b_o;

    modport master (
        input  flush_i, ex_valid_i, ex_addr_i, ex_data_i,
        input  lsu_valid_i, lsu_addr_i, lsu_data_i,
        input  apu_valid_i, apu_addr_i, apu_data_i,
        input  issue_i, issue_addr_i, raddr_a_i, raddr_b_i, raddr_c_i,
        output apu_ready_o, busy_a_o, busy_b_o, busy_c_o,
        output waddr_a_o, wdata_a_o, we_a_o, waddr_b_o, wdata_b_o, we_b_o
    );

    modport slave (
        output flush_i, ex_valid_i, ex_addr_i, ex_data_i,
        output lsu_valid_i, lsu_addr_i, lsu_data_i,
        output apu_valid_i, apu_addr_i, apu_data_i,
        output issue_i, issue_addr_i, raddr_a_i, raddr_b_i, raddr_c_i,
        input  apu_ready_o, busy_a_o, busy_b_o, busy_c_o,
        input  waddr_a_o, wdata_a_o, we_a_o, waddr_b_o, wdata_b_o, we_b_o
    );
endinterface

// File: rtl/cv32e41p_wb_fifo.sv
// APU result FIFO (power-of-two depth, no bypass: a pushed entry becomes
// visible at the head on the cycle after the push).
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush_i     : empty the FIFO at the next edge; a push in that cycle is dropped
//   push_i      : write push_data_i (ignored when full unless popping as well)
//   pop_i       : drop the head entry (ignored when empty)
//   head_o      : oldest entry
//   empty_o/full_o : occupancy flags derived from the count register
module cv32e41p_wb_fifo
    import cv32e41p_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = wb_entry_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush_i,
    input  logic   push_i,
    input  entry_t push_data_i,
    input  logic   pop_i,
    output entry_t head_o,
    output logic   empty_o,
    output logic   full_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign empty_o = (count == '0);
    assign full_o  = (count == CNT_W'(DEPTH));
    assign head_o  = mem[rd_ptr];
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // Power-of-two depth: pointers wrap naturally.
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem[wr_ptr] <= push_data_i;
    end
endmodule

// File: rtl/cv32e41p_rf_wb_arbiter.sv
// Register-file writeback arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   wb         : writeback bundle (master view)
//     EX/LSU results are always accepted; APU results queue in a FIFO.
//     Port A takes EX, else the FIFO head; port B takes LSU, else the FIFO
//     head if it did not go to A. One registered stage to the file ports.
//     A pending-write scoreboard drives busy_a/b/c_o for ID hazard stalls.
module cv32e41p_rf_wb_arbiter
    import cv32e41p_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int APU_DEPTH  = 2
) (
    input logic                    clk,
    input logic                    rst_n,
    cv32e41p_rf_wb_arbiter_if.master wb
);
    localparam int                    NUM_REGS  = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(RF_ZERO_ADDR);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t             fifo_head;
    entry_t             apu_entry;
    logic               fifo_empty;
    logic               fifo_full;
    logic               fifo_push;
    logic               fifo_pop;
    logic               head_avail;
    logic               head_to_a;
    logic               head_to_b;
    entry_t             sel_a;
    entry_t             sel_b;
    logic               sel_a_vld;
    logic               sel_b_vld;
    logic [NUM_REGS-1:0] sb;
    logic [NUM_REGS-1:0] sb_set;
    logic [NUM_REGS-1:0] sb_clr;

    assign apu_entry      = '{addr: wb.apu_addr_i, data: wb.apu_data_i};
    assign wb.apu_ready_o = !fifo_full;
    assign fifo_push      = wb.apu_valid_i && wb.apu_ready_o;
    assign fifo_pop       = head_to_a || head_to_b;

    cv32e41p_wb_fifo #(
        .DEPTH   (APU_DEPTH),
        .entry_t (entry_t)
    ) u_apu_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (wb.flush_i),
        .push_i      (fifo_push),
        .push_data_i (apu_entry),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    // Port selection. The head is held back whenever the other port writes
    // the same register this cycle, so the two file ports never race on it.
    // A flushed head is discarded, never written.
    always_comb begin
        head_avail = !fifo_empty && !wb.flush_i;
        head_to_a  = 1'b0;
        head_to_b  = 1'b0;
        sel_a      = '{addr: wb.ex_addr_i, data: wb.ex_data_i};
        sel_b      = '{addr: wb.lsu_addr_i, data: wb.lsu_data_i};
        sel_a_vld  = wb.ex_valid_i;
        sel_b_vld  = wb.lsu_valid_i;
        if (!wb.ex_valid_i && head_avail &&
            !(wb.lsu_valid_i && wb.lsu_addr_i == fifo_head.addr)) begin
            head_to_a = 1'b1;
            sel_a     = fifo_head;
            sel_a_vld = 1'b1;
        end
        if (!wb.lsu_valid_i && head_avail && !head_to_a &&
            !(wb.ex_valid_i && wb.ex_addr_i == fifo_head.addr)) begin
            head_to_b = 1'b1;
            sel_b     = fifo_head;
            sel_b_vld = 1'b1;
        end
    end

    // Output register stage; nil-register writes are consumed with we low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb.we_a_o    <= 1'b0;
            wb.waddr_a_o <= '0;
            wb.wdata_a_o <= '0;
            wb.we_b_o    <= 1'b0;
            wb.waddr_b_o <= '0;
            wb.wdata_b_o <= '0;
        end else begin
            wb.we_a_o <= sel_a_vld && (sel_a.addr != ZERO_ADDR);
            wb.we_b_o <= sel_b_vld && (sel_b.addr != ZERO_ADDR);
            if (sel_a_vld) begin
                wb.waddr_a_o <= sel_a.addr;
                wb.wdata_a_o <= sel_a.data;
            end
            if (sel_b_vld) begin
                wb.waddr_b_o <= sel_b.addr;
                wb.wdata_b_o <= sel_b.data;
            end
        end
    end

    // Scoreboard: a bit clears on the edge the file captures its write, so
    // busy falls exactly when the data becomes readable. Set beats clear.
    always_comb begin
        sb_set = '0;
        sb_clr = '0;
        if (wb.issue_i && wb.issue_addr_i != ZERO_ADDR) sb_set[wb.issue_addr_i] = 1'b1;
        if (wb.we_a_o) sb_clr[wb.waddr_a_o] = 1'b1;
        if (wb.we_b_o) sb_clr[wb.waddr_b_o] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb <= '0;
        end else if (wb.flush_i) begin
            sb <= '0;
        end else begin
            sb <= (sb & ~sb_clr) | sb_set;
        end
    end

    assign wb.busy_a_o = sb[wb.raddr_a_i];
    assign wb.busy_b_o = sb[wb.raddr_b_i];
    assign wb.busy_c_o = sb[wb.raddr_c_i];

    // EX and LSU must never target the same real register in one cycle.
    ex_lsu_same_addr : assert property (@(posedge clk) disable iff (!rst_n)
        !(wb.ex_valid_i && wb.lsu_valid_i &&
          wb.ex_addr_i == wb.lsu_addr_i && wb.ex_addr_i != ZERO_ADDR));

    apu_push_when_full : assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_push && fifo_full));
endmodule

// File: tb/tb_cv32e41p_rf_wb_arbiter.sv
module tb_cv32e41p_rf_wb_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    cv32e41p_rf_wb_arbiter_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) wb ();

    cv32e41p_rf_wb_arbiter #(
        .ADDR_WIDTH (5),
        .DATA_WIDTH (32),
        .APU_DEPTH  (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb.flush_i     = 1'b0;
        wb.ex_valid_i  = 1'b0;
        wb.lsu_valid_i = 1'b0;
        wb.apu_valid_i = 1'b0;
        wb.issue_i     = 1'b0;
    endtask

    initial begin
        idle();
        wb.ex_addr_i = '0;    wb.ex_data_i = '0;
        wb.lsu_addr_i = '0;   wb.lsu_data_i = '0;
        wb.apu_addr_i = '0;   wb.apu_data_i = '0;
        wb.issue_addr_i = '0;
        wb.raddr_a_i = 5'd10; wb.raddr_b_i = '0; wb.raddr_c_i = '0;

        // reset values
        #2;
        chk("rst_we_a", 32'(wb.we_a_o), 32'd0);
        chk("rst_we_b", 32'(wb.we_b_o), 32'd0);
        chk("rst_waddr_a", 32'(wb.waddr_a_o), 32'd0);
        chk("rst_wdata_a", wb.wdata_a_o, 32'd0);
        chk("rst_waddr_b", 32'(wb.waddr_b_o), 32'd0);
        chk("rst_wdata_b", wb.wdata_b_o, 32'd0);
        chk("rst_ready", 32'(wb.apu_ready_o), 32'd1);
        chk("rst_busy_a", 32'(wb.busy_a_o), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // EX and LSU in the same cycle land on A and B one cycle later
        wb.ex_valid_i = 1'b1;  wb.ex_addr_i = 5'd5;  wb.ex_data_i = 32'hA5A5A5A5;
        wb.lsu_valid_i = 1'b1; wb.lsu_addr_i = 5'd6; wb.lsu_data_i = 32'h12345678;
        tick();
        idle();
        chk("t1_we_a", 32'(wb.we_a_o), 32'd1);
        chk("t1_waddr_a", 32'(wb.waddr_a_o), 32'd5);
        chk("t1_wdata_a", wb.wdata_a_o, 32'hA5A5A5A5);
        chk("t1_we_b", 32'(wb.we_b_o), 32'd1);
        chk("t1_waddr_b", 32'(wb.waddr_b_o), 32'd6);
        chk("t1_wdata_b", wb.wdata_b_o, 32'h12345678);
        tick();
        chk("t1_we_a_idle", 32'(wb.we_a_o), 32'd0);
        chk("t1_we_b_idle", 32'(wb.we_b_o), 32'd0);

        // three APU pushes while EX/LSU occupy both ports
        wb.ex_valid_i = 1'b1;  wb.ex_addr_i = 5'd1;  wb.ex_data_i = 32'h1;
        wb.lsu_valid_i = 1'b1; wb.lsu_addr_i = 5'd2; wb.lsu_data_i = 32'h2;
        wb.apu_valid_i = 1'b1; wb.apu_addr_i = 5'd7; wb.apu_data_i = 32'h77;
        tick();
        chk("t2_ready_1", 32'(wb.apu_ready_o), 32'd1);
        wb.apu_addr_i = 5'd8;  wb.apu_data_i = 32'h88;
        tick();
        chk("t2_ready_full", 32'(wb.apu_ready_o), 32'd0);
        wb.apu_addr_i = 5'd9;  wb.apu_data_i = 32'h99;
        tick();
        chk("t2_ready_held", 32'(wb.apu_ready_o), 32'd0);
        wb.ex_valid_i = 1'b0;  wb.lsu_valid_i = 1'b0;
        tick();
        chk("t2_drain7_we", 32'(wb.we_a_o), 32'd1);
        chk("t2_drain7_addr", 32'(wb.waddr_a_o), 32'd7);
        chk("t2_drain7_data", wb.wdata_a_o, 32'h77);
        chk("t2_drain7_we_b", 32'(wb.we_b_o), 32'd0);
        chk("t2_ready_again", 32'(wb.apu_ready_o), 32'd1);
        tick();
        wb.apu_valid_i = 1'b0;
        chk("t2_drain8_addr", 32'(wb.waddr_a_o), 32'd8);
        chk("t2_drain8_data", wb.wdata_a_o, 32'h88);
        tick();
        chk("t2_drain9_addr", 32'(wb.waddr_a_o), 32'd9);
        chk("t2_drain9_data", wb.wdata_a_o, 32'h99);
        tick();
        chk("t2_empty_we_a", 32'(wb.we_a_o), 32'd0);

        // scoreboard set by issue, cleared by the APU writeback
        wb.issue_i = 1'b1; wb.issue_addr_i = 5'd10;
        tick();
        wb.issue_i = 1'b0;
        wb.raddr_a_i = 5'd10;
        #1;
        chk("t3_busy_set", 32'(wb.busy_a_o), 32'd1);
        wb.apu_valid_i = 1'b1; wb.apu_addr_i = 5'd10; wb.apu_data_i = 32'hCAFEF00D;
        tick();
        wb.apu_valid_i = 1'b0;
        chk("t3_busy_queued", 32'(wb.busy_a_o), 32'd1);
        tick();
        chk("t3_we_a", 32'(wb.we_a_o), 32'd1);
        chk("t3_waddr_a", 32'(wb.waddr_a_o), 32'd10);
        chk("t3_busy_while_we", 32'(wb.busy_a_o), 32'd1);
        tick();
        chk("t3_busy_cleared", 32'(wb.busy_a_o), 32'd0);

        // write to the nil register
        wb.issue_i = 1'b1; wb.issue_addr_i = 5'd11;
        tick();
        wb.issue_i = 1'b0;
        wb.ex_valid_i = 1'b1; wb.ex_addr_i = 5'd0; wb.ex_data_i = 32'hFFFFFFFF;
        wb.raddr_b_i = 5'd11;
        tick();
        wb.ex_valid_i = 1'b0;
        chk("t4_nil_we_a", 32'(wb.we_a_o), 32'd0);
        chk("t4_busy_11", 32'(wb.busy_b_o), 32'd1);
        tick();
        chk("t4_busy_11_kept", 32'(wb.busy_b_o), 32'd1);

        // FIFO head held while EX writes the same register on A
        wb.apu_valid_i = 1'b1; wb.apu_addr_i = 5'd12; wb.apu_data_i = 32'h1212;
        tick();
        wb.apu_valid_i = 1'b0;
        wb.ex_valid_i = 1'b1; wb.ex_addr_i = 5'd12; wb.ex_data_i = 32'hE12;
        tick();
        wb.ex_valid_i = 1'b0;
        chk("t5_ex_data", wb.wdata_a_o, 32'hE12);
        chk("t5_held_we_b", 32'(wb.we_b_o), 32'd0);
        tick();
        chk("t5_head_we_a", 32'(wb.we_a_o), 32'd1);
        chk("t5_head_addr", 32'(wb.waddr_a_o), 32'd12);
        chk("t5_head_data", wb.wdata_a_o, 32'h1212);
        chk("t5_head_we_b", 32'(wb.we_b_o), 32'd0);

        // flush with two queued entries and bits 3,4 pending
        wb.ex_valid_i = 1'b1;  wb.ex_addr_i = 5'd1;  wb.ex_data_i = 32'h1;
        wb.lsu_valid_i = 1'b1; wb.lsu_addr_i = 5'd2; wb.lsu_data_i = 32'h2;
        wb.apu_valid_i = 1'b1; wb.apu_addr_i = 5'd13; wb.apu_data_i = 32'h13;
        wb.issue_i = 1'b1; wb.issue_addr_i = 5'd3;
        tick();
        wb.apu_addr_i = 5'd14; wb.apu_data_i = 32'h14;
        wb.issue_addr_i = 5'd4;
        tick();
        wb.apu_valid_i = 1'b0; wb.issue_i = 1'b0;
        wb.raddr_a_i = 5'd3; wb.raddr_b_i = 5'd4; wb.raddr_c_i = 5'd11;
        #1;
        chk("t6_busy3", 32'(wb.busy_a_o), 32'd1);
        chk("t6_busy4", 32'(wb.busy_b_o), 32'd1);
        chk("t6_full", 32'(wb.apu_ready_o), 32'd0);
        wb.flush_i = 1'b1;
        wb.ex_data_i = 32'h1111; wb.lsu_data_i = 32'h2222;
        wb.issue_i = 1'b1; wb.issue_addr_i = 5'd5;
        tick();
        idle();
        chk("t6_ready", 32'(wb.apu_ready_o), 32'd1);
        chk("t6_busy3_clr", 32'(wb.busy_a_o), 32'd0);
        chk("t6_busy4_clr", 32'(wb.busy_b_o), 32'd0);
        chk("t6_busy11_clr", 32'(wb.busy_c_o), 32'd0);
        chk("t6_ex_still_writes", wb.wdata_a_o, 32'h1111);
        chk("t6_lsu_still_writes", wb.wdata_b_o, 32'h2222);
        wb.raddr_a_i = 5'd5;
        #1;
        chk("t6_issue_ignored", 32'(wb.busy_a_o), 32'd0);
        tick();
        chk("t6_no_drain_a", 32'(wb.we_a_o), 32'd0);
        chk("t6_no_drain_b", 32'(wb.we_b_o), 32'd0);

        // asynchronous reset mid-operation
        wb.ex_valid_i = 1'b1; wb.ex_addr_i = 5'd9; wb.ex_data_i = 32'h9;
        wb.issue_i = 1'b1; wb.issue_addr_i = 5'd20;
        tick();
        idle();
        wb.raddr_a_i = 5'd20;
        #1;
        chk("t7_busy_before", 32'(wb.busy_a_o), 32'd1);
        chk("t7_we_before", 32'(wb.we_a_o), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t7_busy_reset", 32'(wb.busy_a_o), 32'd0);
        chk("t7_we_reset", 32'(wb.we_a_o), 32'd0);
        chk("t7_waddr_reset", 32'(wb.waddr_a_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
